// File: rtl/id_ex_hazard_ctrl_if.sv
// ID-stage decode bundle in, pipeline stall/flush controls and EX-stage control fields out.
// Purely a signal bundle: it adds no latency and no state of its own.
// There is no valid/ready handshake; the ID stage is held through pc_write/if_id_write.
interface id_ex_hazard_ctrl_if;
  // ID-stage inputs from the decoder
  logic [12:0] id_bundle;
  logic        id_branch;
  logic [2:0]  id_cpcode;
  logic        id_ctrl_flush;
  logic        id_badop;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [31:0] id_pc;
  logic        ex_branch_taken;
  logic        kernel_exit;
  // pipeline controls
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        exc_redirect;
  logic [31:0] exc_vector;
  // registered EX-stage control fields
  logic        ex_alusrc1;
  logic        ex_alusrc2;
  logic [3:0]  ex_aluop;
  logic        ex_rtrd;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [1:0]  ex_memtoreg;
  logic        ex_regwrite;
  logic        ex_regdst;
  logic [2:0]  ex_cpcode;
  logic        ex_branch;
  logic [4:0]  ex_rt;
  logic [31:0] epc;
  logic        kernel_mode;

  // decoder / pipeline side
  modport master (
    output id_bundle, id_branch, id_cpcode, id_ctrl_flush, id_badop,
           id_rs, id_rt, id_pc, ex_branch_taken, kernel_exit,
    input  pc_write, if_id_write, if_id_flush, exc_redirect, exc_vector,
           ex_alusrc1, ex_alusrc2, ex_aluop, ex_rtrd, ex_memread, ex_memwrite,
           ex_memtoreg, ex_regwrite, ex_regdst, ex_cpcode, ex_branch, ex_rt,
           epc, kernel_mode
  );

  // hazard controller side
  modport slave (
    input  id_bundle, id_branch, id_cpcode, id_ctrl_flush, id_badop,
           id_rs, id_rt, id_pc, ex_branch_taken, kernel_exit,
    output pc_write, if_id_write, if_id_flush, exc_redirect, exc_vector,
           ex_alusrc1, ex_alusrc2, ex_aluop, ex_rtrd, ex_memread, ex_memwrite,
           ex_memtoreg, ex_regwrite, ex_regdst, ex_cpcode, ex_branch, ex_rt,
           epc, kernel_mode
  );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX control register plus stall/flush/exception steering and user/kernel state with EPC.
// Latency: ID-to-EX 1 cycle; pc_write/if_id_write/if_id_flush/exc_redirect are combinational.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle and inserts an EX bubble.
module id_ex_hazard_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0004
) (
  input  logic              clk,
  input  logic              reset_n,
  id_ex_hazard_ctrl_if.slave bus
);

  typedef enum logic {
    ST_USER   = 1'b0,
    ST_KERNEL = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [12:0] r_ex_bundle;
  logic        r_ex_branch;
  logic [2:0]  r_ex_cpcode;
  logic [4:0]  r_ex_rt;
  logic [31:0] r_epc;

  logic w_branch_flush;
  logic w_exc;
  logic w_load_use;
  logic w_jump;
  logic w_bubble;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;

  // Priority resolution: EX branch flush, then USER exception, then load-use, then jump.
  // A BadOp seen in KERNEL is not an exception but still must not reach EX, so it
  // becomes a bubble and also suppresses any jump flush.
  always_comb begin
    w_branch_flush = 1'b0;
    w_exc          = 1'b0;
    w_load_use     = 1'b0;
    w_jump         = 1'b0;
    w_bubble       = 1'b0;
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_state_nxt    = r_state;

    w_branch_flush = r_ex_branch & bus.ex_branch_taken;
    w_exc          = ~w_branch_flush & bus.id_badop & (r_state == ST_USER);
    w_load_use     = ~w_branch_flush & ~w_exc & r_ex_bundle[5] & (r_ex_rt != 5'd0) &
                     ((r_ex_rt == bus.id_rs) | (r_ex_rt == bus.id_rt));
    w_jump         = ~w_branch_flush & ~w_exc & ~w_load_use & ~bus.id_badop &
                     bus.id_ctrl_flush;

    w_bubble       = w_branch_flush | w_exc | w_load_use | bus.id_badop;
    w_pc_write     = ~w_load_use;
    w_if_id_write  = ~w_load_use;
    w_if_id_flush  = w_branch_flush | w_exc | w_jump;

    case (r_state)
      ST_USER:   if (w_exc)           w_state_nxt = ST_KERNEL;
      ST_KERNEL: if (bus.kernel_exit) w_state_nxt = ST_USER;
      default:                        w_state_nxt = ST_USER;
    endcase
  end

  // User/kernel state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_USER;
    else          r_state <= w_state_nxt;
  end

  // ID/EX control register: either the ID instruction's controls or an all-zero bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_bundle <= '0;
      r_ex_branch <= 1'b0;
      r_ex_cpcode <= '0;
      r_ex_rt     <= '0;
    end else if (w_bubble) begin
      r_ex_bundle <= '0;
      r_ex_branch <= 1'b0;
      r_ex_cpcode <= '0;
      r_ex_rt     <= '0;
    end else begin
      r_ex_bundle <= bus.id_bundle;
      r_ex_branch <= bus.id_branch;
      r_ex_cpcode <= bus.id_cpcode;
      r_ex_rt     <= bus.id_rt;
    end
  end

  // EPC captures the faulting PC only when an exception is actually taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_epc <= '0;
    else if (w_exc) r_epc <= bus.id_pc;
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.if_id_write  = w_if_id_write;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.exc_redirect = w_exc;
  assign bus.exc_vector   = EXC_VECTOR;

  assign bus.ex_alusrc1   = r_ex_bundle[12];
  assign bus.ex_alusrc2   = r_ex_bundle[11];
  assign bus.ex_aluop     = r_ex_bundle[10:7];
  assign bus.ex_rtrd      = r_ex_bundle[6];
  assign bus.ex_memread   = r_ex_bundle[5];
  assign bus.ex_memwrite  = r_ex_bundle[4];
  assign bus.ex_memtoreg  = r_ex_bundle[3:2];
  assign bus.ex_regwrite  = r_ex_bundle[1];
  assign bus.ex_regdst    = r_ex_bundle[0];
  assign bus.ex_branch    = r_ex_branch;
  assign bus.ex_cpcode    = r_ex_cpcode;
  assign bus.ex_rt        = r_ex_rt;
  assign bus.epc          = r_epc;
  assign bus.kernel_mode  = (r_state == ST_KERNEL);

endmodule

// File: doc/id_ex_hazard_ctrl.md
# id_ex_hazard_ctrl

Consumes the decoder's ID-stage outputs: the 13-bit control bundle, Branch/CpCode, CtrlFlush and BadOp. Registers them into the ID/EX control register and unpacks the bundle into EX/MEM/WB control fields. It generates all pipeline stall and flush controls: load-use interlock, jump flush, EX-resolved branch flush and the BadOp exception redirect. It also keeps the user/kernel exception state and the EPC. It sits between the ID-stage decoder and the EX stage.

## Interface
- EXC_VECTOR, 32'h8000_0004, PC loaded on exception redirect (driven out on exc_vector)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- id_bundle  in  13  {ALUSrc1[12], ALUSrc2[11], ALUOp[10:7], RtRd[6], MemRead[5], MemWrite[4], MemtoReg[3:2], RegWrite[1], RegDst[0]}
- id_branch  in  1  ID instruction is a conditional branch
- id_cpcode  in  3  branch compare code (000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz)
- id_ctrl_flush  in  1  ID instruction is j/jal/jr/jalr
- id_badop  in  1  illegal opcode in ID (already gated by PC31 in decoder)
- id_rs, id_rt  in  5 each  ID source register numbers
- id_pc  in  32  PC of ID instruction
- ex_branch_taken  in  1  EX comparator result, meaningful only while ex_branch=1
- kernel_exit  in  1  single-cycle pulse: return from handler
- pc_write, if_id_write  out  1 each  PC / IF-ID register enables
- if_id_flush  out  1  clear IF/ID to nop next edge
- exc_redirect  out  1  PC mux select: load exc_vector
- exc_vector  out  32  constant EXC_VECTOR
- ex_alusrc1, ex_alusrc2, ex_rtrd, ex_memread, ex_memwrite, ex_regwrite, ex_regdst  out  1 each  registered bundle fields
- ex_aluop  out  4;  ex_memtoreg  out  2;  ex_cpcode  out  3;  ex_branch  out  1;  ex_rt  out  5
- epc  out  32  PC of the faulting instruction
- kernel_mode  out  1  state == KERNEL

## Operation
- Bubble: all ex_* fields 0. A bubble writes nothing and does not branch.
- Per-cycle decision, in priority order:
  1. Branch flush: ex_branch & ex_branch_taken. pc_write=1, if_id_flush=1, ID/EX loads a bubble. Any ID BadOp/jump/stall this cycle is wrong-path and ignored.
  2. Exception: id_badop & state==USER. exc_redirect=1, pc_write=1, if_id_flush=1, ID/EX loads a bubble, epc<=id_pc, state<=KERNEL.
  3. Load-use stall: ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt). pc_write=0, if_id_write=0, ID/EX loads a bubble. The ID instruction is held, including a jump.
  4. Jump: id_ctrl_flush. if_id_flush=1, ID/EX loads the jump's bundle (jal/jalr need writeback), pc_write=1.
  5. Normal: ID/EX loads {id_bundle, id_branch, id_cpcode, id_rt}. pc_write=if_id_write=1.
- id_badop in KERNEL: treat as case 5 with a bubble loaded. No EPC update.
- FSM states USER and KERNEL:
  - USER->KERNEL on an accepted exception.
  - KERNEL->USER on kernel_exit.
  - kernel_exit while in USER is ignored.
  - kernel_exit coincident with a new exception in KERNEL: go to USER. The exception is not taken that cycle.
- ex_branch is registered only when id_branch=1 and no flush or stall applies.

## Timing
- pc_write, if_id_write, if_id_flush and exc_redirect are combinational from the inputs and registered EX/state.
- EX fields, epc and state update on the rising clk edge.
- ID-to-EX latency: 1 cycle.
- A load-use stall lasts exactly 1 cycle: the bubble clears ex_memread.
- Branch flush penalty: 2 instructions. Jump penalty: 1 instruction.
- Reset (asynchronous, any cycle, including mid-stall or mid-exception):
  - All ex_* = 0, epc=0, state=USER.
  - Outputs then settle to pc_write=1, if_id_write=1, if_id_flush=0, exc_redirect=0.
- Release reset synchronously to clk in the bench.

## Test plan
- Load-use: lw with MemRead, ex_rt=5, then ID add with id_rs=5 -> one cycle of pc_write=0, if_id_write=0, ex_regwrite=0. Next cycle the add's bundle appears in EX.
- Load to $0: ex_memread=1, ex_rt=0, id_rs=0 -> no stall, pc_write=1.
- Taken branch: ex_branch=1, ex_branch_taken=1, with id_badop=1 and id_pc=32'h0000_0040 -> if_id_flush=1, exc_redirect=0, epc unchanged, state USER, EX bubble.
- BadOp: id_badop=1, id_pc=32'h0000_0100 in USER -> exc_redirect=1, if_id_flush=1. Next edge: epc=32'h0000_0100, kernel_mode=1, EX bubble. A second BadOp is ignored. kernel_exit returns to USER.
- jal in ID (id_ctrl_flush=1, bundle MemtoReg=10, RegWrite=1, RegDst=1) -> if_id_flush=1. Next edge: ex_memtoreg=2'b10, ex_regwrite=1. Coincident load-use stall holds the jal with if_id_flush=0.
- Assert reset_n=0 mid-stall -> outputs reach their reset values immediately, without a clock edge.
